urv_mem_arbiter: RTL and testbench
==================================

Name: urv_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the urv_cpu instruction fetch port (im_*) and data port (dm_*). The RAM holds unified code and data.
- Sits between the CPU and the RAM macro; replaces the dual-ported memory model at the system level.
- Sequences one RAM access per cycle and returns the valid/done handshakes the CPU expects.
- Gives the data port priority, with a bounded-starvation guarantee for fetches.

Parameters:
g_addr_width, 14, RAM word-address bits (2^14 = 16384 words); byte addresses wrap modulo 2^(g_addr_width+2).
g_max_dm_burst, 4, max consecutive dm grants while a fetch is pending; range 1..15.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
im_addr_i  in  32  fetch byte address, sampled with im_rd_i
im_rd_i  in  1  fetch strobe, 1 cycle
im_data_o  out  32  fetched word
im_valid_o  out  1  im_data_o valid, 1-cycle pulse
dm_addr_i  in  32  data byte address
dm_data_s_i  in  32  store data
dm_data_select_i  in  4  store byte enables
dm_store_i  in  1  store strobe, 1 cycle
dm_load_i  in  1  load strobe, 1 cycle
dm_data_l_o  out  32  load data
dm_load_done_o  out  1  load complete, 1-cycle pulse
dm_store_done_o  out  1  store complete, 1-cycle pulse
ram_en_o  out  1  RAM access enable
ram_addr_o  out  g_addr_width  RAM word address = byte addr[g_addr_width+1:2]
ram_we_o  out  4  RAM byte write enables; 0 = read
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o with ram_we_o=0

Behaviour:
- Reset: all outputs are 0. Pending flags, in-flight tags and the streak counter are cleared. Reset mid-access drops the access silently; no valid/done pulse is generated afterwards.
- Capture (edge E0): a strobe sets its port's pending flag and latches addr/data/select.
  - Fetch: an im_rd_i while a fetch is already pending overwrites the latched address (newest fetch wins).
  - Data: dm_store_i and dm_load_i in the same cycle → store wins, load dropped.
  - A new dm strobe while dm is pending is a protocol violation; the new strobe is ignored.
- Grant (edge E1): registered ram_* outputs are driven from the winner's latched request and its pending flag is cleared.
  - dm pending and streak < g_max_dm_burst → dm wins.
  - Otherwise, if im is pending → im wins.
  - Otherwise ram_en_o=0 and ram_we_o=0.
- Streak counter:
  - Increments on each dm grant made while im is pending.
  - Clears on any im grant, and in any cycle where im is not pending.
- Response (registered):
  - Load: rdata captured at E3, dm_data_l_o updated, dm_load_done_o high for cycle E3..E4.
  - Store: ram_we_o = dm_data_select_i, dm_store_done_o high for cycle E2..E3.
  - Fetch: im_data_o/im_valid_o at E3, same timing as a load.
  - Latency from strobe edge: load/fetch 3 cycles, store 2 cycles.
- Throughput: one grant per cycle. Grant and response stages are pipelined, so back-to-back grants of either port are legal.
- Fetch kill: if im_rd_i arrives while an earlier fetch is already granted and in flight, the in-flight response is squashed (no im_valid_o pulse) and the new fetch is queued normally. im_valid_o is never asserted for a superseded address.
- Store with dm_data_select_i=0: a RAM cycle is still consumed (ram_en_o=1, ram_we_o=0), the read data is discarded, and dm_store_done_o still pulses.
- Address wrap: upper address bits are ignored; no error or exception is raised.
- dm_data_l_o and im_data_o hold their last value between pulses.

Test Plan:
- Reset, then single load of 0x0000_0040 with RAM word 16 = 0xDEADBEEF → ram_en_o/ram_addr_o=16 one cycle after the strobe; dm_load_done_o pulses exactly 3 cycles after the strobe with dm_data_l_o=0xDEADBEEF.
- Store 0x11223344 to 0x8, select=4'b0101, then load 0x8 (word previously 0xAAAAAAAA) → ram_we_o=0101 in the grant cycle, store_done at +2; the load returns 0xAA22AA44.
- Fetch held pending while dm strobes every cycle, g_max_dm_burst=4 → grants in the order dm,dm,dm,dm,im,dm…; im_valid_o within 7 cycles of im_rd_i.
- im_rd_i to 0x100, then im_rd_i to 0x200 one cycle later (first fetch in flight) → no response for 0x100; exactly one im_valid_o, carrying RAM word 0x80.
- Simultaneous im_rd_i(0x0) and dm_load_i(0x4) → RAM order is dm then im; load_done and im_valid_o pulse on consecutive cycles.
- Assert rst_i in the cycle after a load grant → all outputs go to 0 immediately; no dm_load_done_o pulse appears after reset deassertion.

Source files
------------

// File: rtl/urv_mem_arbiter.sv
// Single-port RAM arbiter for the urv CPU: multiplexes instruction fetches and
// data loads/stores onto one synchronous RAM, data port first, fetch starvation bounded.
module urv_mem_arbiter #(
  parameter int g_addr_width   = 14,
  parameter int g_max_dm_burst = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             im_addr_i,
  input  logic                    im_rd_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  input  logic [31:0]             dm_addr_i,
  input  logic [31:0]             dm_data_s_i,
  input  logic [3:0]              dm_data_select_i,
  input  logic                    dm_store_i,
  input  logic                    dm_load_i,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic                    ram_en_o,
  output logic [g_addr_width-1:0] ram_addr_o,
  output logic [3:0]              ram_we_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i
);

  localparam int          AW        = g_addr_width;
  localparam logic [3:0]  MAX_BURST = 4'(g_max_dm_burst);

  // Latched requests (capture stage)
  logic          im_pend_q, im_pend_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic          dm_pend_q, dm_pend_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]   dm_wdata_q, dm_wdata_d;
  logic [3:0]    dm_sel_q, dm_sel_d;
  logic          dm_is_store_q, dm_is_store_d;
  logic [3:0]    streak_q, streak_d;

  // Grant stage registers
  logic          ram_en_q, ram_en_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]    ram_we_q, ram_we_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          tag_ld_p1_q, tag_ld_p1_d;
  logic          tag_st_p1_q, tag_st_p1_d;
  logic          tag_im_p1_q, tag_im_p1_d;

  // RAM read-latency stage and response registers
  logic          tag_ld_p2_q, tag_ld_p2_d;
  logic          tag_im_p2_q, tag_im_p2_d;
  logic          dm_load_done_q, dm_load_done_d;
  logic          dm_store_done_q, dm_store_done_d;
  logic          im_valid_q, im_valid_d;
  logic [31:0]   dm_data_l_q, dm_data_l_d;
  logic [31:0]   im_data_q, im_data_d;

  logic grant_dm, grant_im, dm_strobe, dm_accept;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr_i[31:AW+2], im_addr_i[1:0],
                              dm_addr_i[31:AW+2], dm_addr_i[1:0]};

  always_comb begin
    // A fetch strobed this cycle supersedes whatever is pending, so granting
    // the stale address would only produce a response that must be squashed.
    grant_dm  = dm_pend_q && (streak_q < MAX_BURST);
    grant_im  = !grant_dm && im_pend_q && !im_rd_i;
    dm_strobe = dm_store_i || dm_load_i;
    dm_accept = dm_strobe && (!dm_pend_q || grant_dm);

    im_pend_d     = im_rd_i || (im_pend_q && !grant_im);
    im_addr_d     = im_rd_i ? im_addr_i[AW+1:2] : im_addr_q;
    dm_pend_d     = dm_accept || (dm_pend_q && !grant_dm);
    dm_addr_d     = dm_accept ? dm_addr_i[AW+1:2] : dm_addr_q;
    dm_wdata_d    = dm_accept ? dm_data_s_i : dm_wdata_q;
    dm_sel_d      = dm_accept ? dm_data_select_i : dm_sel_q;
    dm_is_store_d = dm_accept ? dm_store_i : dm_is_store_q;

    streak_d = streak_q;
    if (!im_pend_q || grant_im)
      streak_d = '0;
    else if (grant_dm)
      streak_d = streak_q + 4'd1;

    ram_en_d    = grant_dm || grant_im;
    ram_addr_d  = '0;
    ram_we_d    = '0;
    ram_wdata_d = '0;
    if (grant_dm) begin
      ram_addr_d  = dm_addr_q;
      ram_we_d    = dm_is_store_q ? dm_sel_q : 4'b0000;
      ram_wdata_d = dm_wdata_q;
    end else if (grant_im) begin
      ram_addr_d  = im_addr_q;
    end
    tag_ld_p1_d = grant_dm && !dm_is_store_q;
    tag_st_p1_d = grant_dm && dm_is_store_q;
    tag_im_p1_d = grant_im;

    // Any new fetch kills fetches already in flight.
    tag_ld_p2_d     = tag_ld_p1_q;
    tag_im_p2_d     = tag_im_p1_q && !im_rd_i;
    dm_store_done_d = tag_st_p1_q;

    dm_load_done_d = tag_ld_p2_q;
    dm_data_l_d    = tag_ld_p2_q ? ram_rdata_i : dm_data_l_q;
    im_valid_d     = tag_im_p2_q && !im_rd_i;
    im_data_d      = im_valid_d ? ram_rdata_i : im_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      im_pend_q       <= 1'b0;
      dm_pend_q       <= 1'b0;
      streak_q        <= '0;
      ram_en_q        <= 1'b0;
      ram_addr_q      <= '0;
      ram_we_q        <= '0;
      ram_wdata_q     <= '0;
      tag_ld_p1_q     <= 1'b0;
      tag_st_p1_q     <= 1'b0;
      tag_im_p1_q     <= 1'b0;
      tag_ld_p2_q     <= 1'b0;
      tag_im_p2_q     <= 1'b0;
      dm_load_done_q  <= 1'b0;
      dm_store_done_q <= 1'b0;
      im_valid_q      <= 1'b0;
      dm_data_l_q     <= '0;
      im_data_q       <= '0;
    end else begin
      im_pend_q       <= im_pend_d;
      dm_pend_q       <= dm_pend_d;
      streak_q        <= streak_d;
      ram_en_q        <= ram_en_d;
      ram_addr_q      <= ram_addr_d;
      ram_we_q        <= ram_we_d;
      ram_wdata_q     <= ram_wdata_d;
      tag_ld_p1_q     <= tag_ld_p1_d;
      tag_st_p1_q     <= tag_st_p1_d;
      tag_im_p1_q     <= tag_im_p1_d;
      tag_ld_p2_q     <= tag_ld_p2_d;
      tag_im_p2_q     <= tag_im_p2_d;
      dm_load_done_q  <= dm_load_done_d;
      dm_store_done_q <= dm_store_done_d;
      im_valid_q      <= im_valid_d;
      dm_data_l_q     <= dm_data_l_d;
      im_data_q       <= im_data_d;
    end
  end

  // Request payloads are only meaningful while their pending flag is set.
  always_ff @(posedge clk_i) begin
    im_addr_q     <= im_addr_d;
    dm_addr_q     <= dm_addr_d;
    dm_wdata_q    <= dm_wdata_d;
    dm_sel_q      <= dm_sel_d;
    dm_is_store_q <= dm_is_store_d;
  end

  assign ram_en_o        = ram_en_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_we_o        = ram_we_q;
  assign ram_wdata_o     = ram_wdata_q;
  assign dm_load_done_o  = dm_load_done_q;
  assign dm_store_done_o = dm_store_done_q;
  assign dm_data_l_o     = dm_data_l_q;
  assign im_valid_o      = im_valid_q;
  assign im_data_o       = im_data_q;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter with a behavioural single-port RAM.
module tb_urv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im_addr = '0;
  logic        im_rd = 1'b0;
  logic [31:0] im_data;
  logic        im_valid;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_data_s = '0;
  logic [3:0]  dm_sel = '0;
  logic        dm_store = 1'b0;
  logic        dm_load = 1'b0;
  logic [31:0] dm_data_l;
  logic        dm_load_done;
  logic        dm_store_done;
  logic        ram_en;
  logic [13:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int total = 0;
  int bad = 0;

  urv_mem_arbiter #(.g_addr_width(14), .g_max_dm_burst(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .im_addr_i(im_addr), .im_rd_i(im_rd), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(dm_store), .dm_load_i(dm_load), .dm_data_l_o(dm_data_l),
    .dm_load_done_o(dm_load_done), .dm_store_done_o(dm_store_done),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (rst) begin
      mem[0]    <= 32'hC0DE0000;
      mem[1]    <= 32'h0000D001;
      mem[2]    <= 32'hAAAAAAAA;
      mem[16]   <= 32'hDEADBEEF;
      mem[14'h40] <= 32'h11110100;
      mem[14'h80] <= 32'h22220200;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] got;

    tick(); tick();
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_im_valid", 32'(im_valid), 32'd0);
    chk("rst_ld_done", 32'(dm_load_done), 32'd0);
    chk("rst_st_done", 32'(dm_store_done), 32'd0);
    chk("rst_dm_data", dm_data_l, 32'd0);
    rst = 1'b0;
    tick();

    // single load of 0x40
    dm_addr = 32'h40; dm_load = 1'b1;
    tick(); dm_load = 1'b0;
    chk("ld_e0_en", 32'(ram_en), 32'd0);
    tick();
    chk("ld_e1_en", 32'(ram_en), 32'd1);
    chk("ld_e1_addr", 32'(ram_addr), 32'd16);
    chk("ld_e1_we", 32'(ram_we), 32'd0);
    tick();
    chk("ld_e2_done", 32'(dm_load_done), 32'd0);
    tick();
    chk("ld_e3_done", 32'(dm_load_done), 32'd1);
    chk("ld_e3_data", dm_data_l, 32'hDEADBEEF);
    tick();
    chk("ld_e4_done", 32'(dm_load_done), 32'd0);
    chk("ld_e4_hold", dm_data_l, 32'hDEADBEEF);

    // partial store then load back
    dm_addr = 32'h8; dm_data_s = 32'h11223344; dm_sel = 4'b0101; dm_store = 1'b1;
    tick(); dm_store = 1'b0;
    tick();
    chk("st_e1_we", 32'(ram_we), 32'h5);
    chk("st_e1_addr", 32'(ram_addr), 32'd2);
    chk("st_e1_wdata", ram_wdata, 32'h11223344);
    chk("st_e1_done", 32'(dm_store_done), 32'd0);
    tick();
    chk("st_e2_done", 32'(dm_store_done), 32'd1);
    tick();
    chk("st_e3_done", 32'(dm_store_done), 32'd0);
    dm_load = 1'b1;
    tick(); dm_load = 1'b0;
    tick(); tick(); tick();
    chk("st_ld_done", 32'(dm_load_done), 32'd1);
    chk("st_ld_data", dm_data_l, 32'hAA22AA44);
    tick();

    // fetch held off by a dm burst of 4
    im_addr = 32'h100; im_rd = 1'b1; dm_addr = 32'h40; dm_load = 1'b1;
    tick(); im_rd = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("burst_dm%0d", k), 32'(ram_addr), 32'd16);
    end
    tick();
    chk("burst_im_addr", 32'(ram_addr), 32'h40);
    chk("burst_im_en", 32'(ram_en), 32'd1);
    tick();
    chk("burst_dm_after", 32'(ram_addr), 32'd16);
    chk("burst_im_v6", 32'(im_valid), 32'd0);
    dm_load = 1'b0;
    tick();
    chk("burst_im_v7", 32'(im_valid), 32'd1);
    chk("burst_im_data", im_data, 32'h11110100);
    tick(); tick(); tick(); tick();

    // newer fetch kills the earlier one
    im_addr = 32'h100; im_rd = 1'b1;
    tick(); im_addr = 32'h200;
    tick(); im_rd = 1'b0;
    chk("kill_hold_data", im_data, 32'h11110100);
    cnt = 0; got = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (im_valid) begin cnt++; got = im_data; end
    end
    chk("kill_count", 32'(cnt), 32'd1);
    chk("kill_data", got, 32'h22220200);

    // simultaneous fetch and load: dm first
    im_addr = 32'h0; im_rd = 1'b1; dm_addr = 32'h4; dm_load = 1'b1;
    tick(); im_rd = 1'b0; dm_load = 1'b0;
    tick();
    chk("sim_first", 32'(ram_addr), 32'd1);
    tick();
    chk("sim_second", 32'(ram_addr), 32'd0);
    chk("sim_second_en", 32'(ram_en), 32'd1);
    tick();
    chk("sim_ld_done", 32'(dm_load_done), 32'd1);
    chk("sim_ld_data", dm_data_l, 32'h0000D001);
    chk("sim_im_early", 32'(im_valid), 32'd0);
    tick();
    chk("sim_im_valid", 32'(im_valid), 32'd1);
    chk("sim_im_data", im_data, 32'hC0DE0000);
    chk("sim_ld_off", 32'(dm_load_done), 32'd0);

    // store with empty byte mask still occupies the RAM
    dm_addr = 32'h8; dm_data_s = 32'hFFFFFFFF; dm_sel = 4'b0000; dm_store = 1'b1;
    tick(); dm_store = 1'b0;
    tick();
    chk("st0_en", 32'(ram_en), 32'd1);
    chk("st0_we", 32'(ram_we), 32'd0);
    tick();
    chk("st0_done", 32'(dm_store_done), 32'd1);
    tick();
    chk("st0_no_ld", 32'(dm_load_done), 32'd0);
    chk("st0_ld_hold", dm_data_l, 32'h0000D001);

    // wrapped address, then reset in the cycle after the grant
    dm_addr = 32'hFFFF_0040; dm_load = 1'b1;
    tick(); dm_load = 1'b0;
    tick();
    chk("wrap_addr", 32'(ram_addr), 32'd16);
    chk("wrap_en", 32'(ram_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_en", 32'(ram_en), 32'd0);
    chk("arst_addr", 32'(ram_addr), 32'd0);
    chk("arst_dm_data", dm_data_l, 32'd0);
    chk("arst_im_data", im_data, 32'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (dm_load_done) cnt++;
    end
    chk("arst_no_done", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
